ps2_key_framer: RTL and testbench



---
 rtl/ps2_key_framer.sv | 196 +++++++++++++++++++
 tb/tb_ps2_key_framer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_framer.sv
// PS/2 device-to-host receiver: conditions the raw pins, deserialises frames and folds prefix bytes
// into one 65-bit toggle-flagged event word. Define PS2_KEY_MULTIBYTE_EN to merge Pause and Print Screen.
module ps2_key_framer #(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 60000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [64:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0);
  endfunction

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic          filt_clk_r;
  logic [FW-1:0] filt_cnt_r;
  logic          strobe_s;
  logic          data_s;

  state_t        state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [63:0]   acc_r;
  logic [3:0]    cnt_r;
  logic [TW-1:0] idle_cnt_r;

  logic [63:0]   acc_next_s;
  logic [3:0]    cnt_next_s;
  logic          complete_s;

  assign data_s = data_sync_r[1];

  // Synchronise both pins and debounce the clock line into filt_clk_r.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      filt_clk_r  <= 1'b1;
      filt_cnt_r  <= {FW{1'b0}};
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
      if (clk_sync_r[1] != filt_clk_r) begin
        if (filt_cnt_r == FW'(FILT - 1)) begin
          filt_clk_r <= clk_sync_r[1];
          filt_cnt_r <= {FW{1'b0}};
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
        end
      end else begin
        filt_cnt_r <= {FW{1'b0}};
      end
    end
  end

  // Strobe fires on the cycle the filtered clock is about to fall, so data is sampled in step with it.
  always_comb begin
    strobe_s = 1'b0;
    if (filt_clk_r && !clk_sync_r[1] && (filt_cnt_r == FW'(FILT - 1))) begin
      strobe_s = 1'b1;
    end else begin
      strobe_s = 1'b0;
    end
  end

  // Decide whether the byte in shift_r closes the current scan-code sequence.
  always_comb begin
    acc_next_s = {acc_r[55:0], shift_r};
    cnt_next_s = cnt_r + 4'd1;
    complete_s = 1'b0;
`ifdef PS2_KEY_MULTIBYTE_EN
    if (cnt_next_s == 4'd8) begin
      complete_s = 1'b1;
    end else if (acc_next_s[{cnt_r[2:0], 3'b000} +: 8] == 8'hE1) begin
      // First byte of the sequence was E1: Pause runs to eight bytes.
      complete_s = 1'b0;
    end else if (is_prefix(shift_r)) begin
      complete_s = 1'b0;
    end else if ((cnt_next_s == 4'd2) && (acc_next_s[15:0] == 16'hE012)) begin
      complete_s = 1'b0;
    end else if ((cnt_next_s == 4'd3) && (acc_next_s[23:0] == 24'hE0F07C)) begin
      complete_s = 1'b0;
    end else begin
      complete_s = 1'b1;
    end
`else
    if (cnt_next_s == 4'd8) begin
      complete_s = 1'b1;
    end else if (is_prefix(shift_r) || (shift_r == 8'hE1)) begin
      complete_s = 1'b0;
    end else begin
      complete_s = 1'b1;
    end
`endif
  end

  // Frame FSM, sequencer and idle timeout; all outputs are registered here.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      acc_r      <= 64'd0;
      cnt_r      <= 4'd0;
      idle_cnt_r <= {TW{1'b0}};
      ps2_key    <= 65'd0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (strobe_s) begin
        idle_cnt_r <= {TW{1'b0}};
        case (state_r)
          ST_IDLE: begin
            if (!data_s) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_DATA: begin
            shift_r   <= {data_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_PARITY: begin
            if (odd_parity_ok(shift_r, data_s)) begin
              state_r <= ST_STOP;
            end else begin
              state_r   <= ST_IDLE;
              frame_err <= 1'b1;
              acc_r     <= 64'd0;
              cnt_r     <= 4'd0;
            end
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (!data_s) begin
              frame_err <= 1'b1;
              acc_r     <= 64'd0;
              cnt_r     <= 4'd0;
            end else if (complete_s) begin
              // Bytes and toggle move together so a consumer never sees a toggle with stale bytes.
              ps2_key <= {~ps2_key[64], acc_next_s};
              acc_r   <= 64'd0;
              cnt_r   <= 4'd0;
            end else begin
              acc_r <= acc_next_s;
              cnt_r <= cnt_next_s;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else if ((state_r != ST_IDLE) || (cnt_r != 4'd0)) begin
        if (idle_cnt_r == TW'(TIMEOUT - 1)) begin
          idle_cnt_r <= {TW{1'b0}};
          frame_err  <= (state_r != ST_IDLE);
          state_r    <= ST_IDLE;
          acc_r      <= 64'd0;
          cnt_r      <= 4'd0;
        end else begin
          idle_cnt_r <= idle_cnt_r + TW'(1);
        end
      end else begin
        idle_cnt_r <= {TW{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_framer.sv
// Directed self-checking bench for ps2_key_framer; expectations follow the build's PS2_KEY_MULTIBYTE_EN setting.
module tb_ps2_key_framer;

  localparam int FILT    = 4;
  localparam int TIMEOUT = 1500;
  localparam int HALF    = 20;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [64:0] ps2_key;
  logic        frame_err;

  int   total = 0;
  int   bad = 0;
  int   ev_cnt = 0;
  int   err_cnt = 0;
  logic last_tog = 1'b0;
  logic exp_tog = 1'b0;

  ps2_key_framer #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Count toggles of bit 64 and frame_err pulses outside reset.
  always @(negedge clk_sys) begin
    if (reset_n && (ps2_key[64] != last_tog)) ev_cnt <= ev_cnt + 1;
    if (reset_n && frame_err) err_cnt <= err_cnt + 1;
    last_tog <= ps2_key[64];
  end

  task automatic send_bit(input logic b);
    @(negedge clk_sys);
    ps2_data = b;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    @(negedge clk_sys);
    ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk_sys);
    total++;
    if (ps2_key !== 65'd0) begin bad++; $display("FAIL reset_key: got %h want 0", ps2_key); end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
    reset_n = 1'b1;
    settle();
  endtask

  task automatic test_single();
    int ev0 = ev_cnt;
    int er0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    settle();
    exp_tog = ~exp_tog;
    total++;
    if ((ev_cnt - ev0) !== 1) begin bad++; $display("FAIL single_events: got %0d want 1", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'h1C) begin bad++; $display("FAIL single_key: got %h want 1c", ps2_key[63:0]); end
    total++;
    if (ps2_key[64] !== 1'b1) begin bad++; $display("FAIL single_toggle: got %b want 1", ps2_key[64]); end
    total++;
    if ((err_cnt - er0) !== 0) begin bad++; $display("FAIL single_err: got %0d want 0", err_cnt - er0); end
  endtask

  task automatic test_break();
    int ev0 = ev_cnt;
    send_frame(8'hF0, 1'b0, 1'b0);
    settle();
    total++;
    if ((ev_cnt - ev0) !== 0) begin bad++; $display("FAIL break_prefix_events: got %0d want 0", ev_cnt - ev0); end
    send_frame(8'h1C, 1'b0, 1'b0);
    settle();
    exp_tog = ~exp_tog;
    total++;
    if ((ev_cnt - ev0) !== 1) begin bad++; $display("FAIL break_events: got %0d want 1", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'hF01C) begin bad++; $display("FAIL break_key: got %h want f01c", ps2_key[63:0]); end
    total++;
    if (ps2_key[64] !== exp_tog) begin bad++; $display("FAIL break_toggle: got %b want %b", ps2_key[64], exp_tog); end
  endtask

  task automatic test_ext_break();
    int ev0 = ev_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    settle();
    exp_tog = ~exp_tog;
    total++;
    if ((ev_cnt - ev0) !== 1) begin bad++; $display("FAIL extbrk_events: got %0d want 1", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'hE0F075) begin bad++; $display("FAIL extbrk_key: got %h want e0f075", ps2_key[63:0]); end
  endtask

  task automatic test_printscreen();
    int ev0 = ev_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0);
    settle();
`ifdef PS2_KEY_MULTIBYTE_EN
    total++;
    if ((ev_cnt - ev0) !== 0) begin bad++; $display("FAIL prtsc_hold: got %0d want 0", ev_cnt - ev0); end
`else
    total++;
    if (ps2_key[63:0] !== 64'hE012) begin bad++; $display("FAIL prtsc_first: got %h want e012", ps2_key[63:0]); end
`endif
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h7C, 1'b0, 1'b0);
    settle();
`ifdef PS2_KEY_MULTIBYTE_EN
    total++;
    if ((ev_cnt - ev0) !== 1) begin bad++; $display("FAIL prtsc_events: got %0d want 1", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'hE012E07C) begin bad++; $display("FAIL prtsc_key: got %h want e012e07c", ps2_key[63:0]); end
`else
    exp_tog = ~exp_tog;
    total++;
    if ((ev_cnt - ev0) !== 2) begin bad++; $display("FAIL prtsc_events: got %0d want 2", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'hE07C) begin bad++; $display("FAIL prtsc_key: got %h want e07c", ps2_key[63:0]); end
`endif
    exp_tog = ~exp_tog;
  endtask

  task automatic test_parity_err();
    int ev0 = ev_cnt;
    int er0 = err_cnt;
    send_frame(8'h29, 1'b1, 1'b0);
    settle();
    total++;
    if ((err_cnt - er0) !== 1) begin bad++; $display("FAIL parity_err: got %0d want 1", err_cnt - er0); end
    total++;
    if ((ev_cnt - ev0) !== 0) begin bad++; $display("FAIL parity_noevent: got %0d want 0", ev_cnt - ev0); end
    send_frame(8'h29, 1'b0, 1'b0);
    settle();
    exp_tog = ~exp_tog;
    total++;
    if ((ev_cnt - ev0) !== 1) begin bad++; $display("FAIL parity_recover_ev: got %0d want 1", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'h29) begin bad++; $display("FAIL parity_recover_key: got %h want 29", ps2_key[63:0]); end
  endtask

  task automatic test_stop_err();
    int ev0 = ev_cnt;
    int er0 = err_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    settle();
    total++;
    if ((err_cnt - er0) !== 1) begin bad++; $display("FAIL stop_err: got %0d want 1", err_cnt - er0); end
    total++;
    if ((ev_cnt - ev0) !== 0) begin bad++; $display("FAIL stop_noevent: got %0d want 0", ev_cnt - ev0); end
    send_frame(8'h5A, 1'b0, 1'b0);
    settle();
    exp_tog = ~exp_tog;
    total++;
    if (ps2_key[63:0] !== 64'h5A) begin bad++; $display("FAIL stop_seq_cleared: got %h want 5a", ps2_key[63:0]); end
  endtask

  task automatic test_timeout();
    int ev0 = ev_cnt;
    int er0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk_sys);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk_sys);
    total++;
    if ((err_cnt - er0) !== 1) begin bad++; $display("FAIL timeout_err: got %0d want 1", err_cnt - er0); end
    total++;
    if ((ev_cnt - ev0) !== 0) begin bad++; $display("FAIL timeout_noevent: got %0d want 0", ev_cnt - ev0); end
    send_frame(8'h1D, 1'b0, 1'b0);
    settle();
    exp_tog = ~exp_tog;
    total++;
    if (ps2_key[63:0] !== 64'h1D) begin bad++; $display("FAIL timeout_recover_key: got %h want 1d", ps2_key[63:0]); end
    total++;
    if (ps2_key[64] !== exp_tog) begin bad++; $display("FAIL timeout_toggle: got %b want %b", ps2_key[64], exp_tog); end
  endtask

  task automatic test_seq_timeout();
    int ev0 = ev_cnt;
    int er0 = err_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    repeat (TIMEOUT + 50) @(negedge clk_sys);
    total++;
    if ((err_cnt - er0) !== 0) begin bad++; $display("FAIL seqto_err: got %0d want 0", err_cnt - er0); end
    send_frame(8'h75, 1'b0, 1'b0);
    settle();
    exp_tog = ~exp_tog;
    total++;
    if ((ev_cnt - ev0) !== 1) begin bad++; $display("FAIL seqto_events: got %0d want 1", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'h75) begin bad++; $display("FAIL seqto_key: got %h want 75", ps2_key[63:0]); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'hE0, 1'b0, 1'b0);
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    total++;
    if (ps2_key !== 65'd0) begin bad++; $display("FAIL rstmid_key: got %h want 0", ps2_key); end
    reset_n = 1'b1;
    exp_tog = 1'b0;
    settle();
    send_frame(8'h75, 1'b0, 1'b0);
    settle();
    exp_tog = ~exp_tog;
    total++;
    if (ps2_key[63:0] !== 64'h75) begin bad++; $display("FAIL rstmid_after_key: got %h want 75", ps2_key[63:0]); end
    total++;
    if (ps2_key[64] !== 1'b1) begin bad++; $display("FAIL rstmid_toggle: got %b want 1", ps2_key[64]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int ev0 = ev_cnt;
    for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0, 1'b0);
    settle();
`ifdef PS2_KEY_MULTIBYTE_EN
    total++;
    if ((ev_cnt - ev0) !== 1) begin bad++; $display("FAIL pause_events: got %0d want 1", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'hE11477E1F014F077) begin bad++; $display("FAIL pause_key: got %h want e11477e1f014f077", ps2_key[63:0]); end
`else
    total++;
    if ((ev_cnt - ev0) !== 4) begin bad++; $display("FAIL pause_events: got %0d want 4", ev_cnt - ev0); end
    total++;
    if (ps2_key[63:0] !== 64'hF077) begin bad++; $display("FAIL pause_key: got %h want f077", ps2_key[63:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_ext_break();
    test_printscreen();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_seq_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
